// File: rtl/serial_port.sv
// Link-port controller: SB/SC registers, 8-bit MSB-first shifter with internal or external clock.
// Build option: define SERIAL_LOOPBACK_EN to feed sout back into the shifter instead of sin.

`ifndef MMIO_SB
`define MMIO_SB 16'hFF01
`endif
`ifndef MMIO_SC
`define MMIO_SC 16'hFF02
`endif

module serial_port #(
  parameter int unsigned HALF_PERIOD = 256,
  parameter logic [15:0] SB_ADDR     = `MMIO_SB,
  parameter logic [15:0] SC_ADDR     = `MMIO_SC
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        sin,
  input  logic        sclk_in,
  output logic        sout,
  output logic        sclk_out,
  output logic        serial_interrupt
);

  localparam int unsigned DIV_W = $clog2(HALF_PERIOD) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         sb_q, sb_d;
  logic               start_q, start_d;
  logic               int_clk_q, int_clk_d;
  logic               mode_q, mode_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;
  logic               irq_q;
  logic [2:0]         sync_q;

  logic               sel_sb, sel_sc;
  logic               wr_sb, wr_sc;
  logic [7:0]         wdata;
  logic               shift_in;
  logic               div_tick;
  logic               int_rise, int_fall;
  logic               ext_rise, ext_fall;
  logic               bit_rise, bit_fall;
  logic               complete;

  assign sel_sb = (addr_ext == SB_ADDR);
  assign sel_sc = (addr_ext == SC_ADDR);
  assign wr_sb  = mem_we & sel_sb;
  assign wr_sc  = mem_we & sel_sc;
  assign wdata  = data_ext;

  // Bus read path: combinational drive only while addressed, released otherwise.
  assign data_ext = (mem_re && sel_sb) ? sb_q :
                    (mem_re && sel_sc) ? {start_q, 6'b111111, int_clk_q} :
                    8'hzz;

`ifdef SERIAL_LOOPBACK_EN
  assign shift_in = sout_q;
`else
  assign shift_in = sin;
`endif

  // sync_q[1] is the synchronized external clock, sync_q[2] its previous value.
  assign ext_rise = sync_q[1] & ~sync_q[2];
  assign ext_fall = ~sync_q[1] & sync_q[2];

  assign div_tick = (state_q == ST_SHIFT) && mode_q && (div_q == DIV_LAST);
  assign int_rise = div_tick & ~sclk_q;
  assign int_fall = div_tick & sclk_q;

  assign bit_rise = (state_q == ST_SHIFT) && (mode_q ? int_rise : ext_rise);
  assign bit_fall = (state_q == ST_SHIFT) && (mode_q ? int_fall : ext_fall);
  assign complete = bit_rise && (cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    start_d   = start_q;
    int_clk_d = int_clk_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    sout_d    = sout_q;
    done_d    = 1'b0;

    if (wr_sc) begin
      start_d   = wdata[7];
      int_clk_d = wdata[0];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_sb) sb_d = wdata;
        if (wr_sc && wdata[7]) begin
          state_d = ST_SHIFT;
          cnt_d   = 3'd0;
          div_d   = '0;
          sclk_d  = 1'b1;
          sout_d  = sb_q[7];
          mode_d  = wdata[0];
        end
      end

      ST_SHIFT: begin
        if (mode_q) begin
          if (div_tick) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end else begin
          sclk_d = 1'b1;
        end

        // The very first falling edge only re-drives the bit already presented on entry.
        if (bit_fall && (cnt_q != 3'd0)) sout_d = sb_q[7];

        if (bit_rise) begin
          sb_d   = {sb_q[6:0], shift_in};
          cnt_d  = cnt_q + 3'd1;
          div_d  = '0;
          sclk_d = 1'b1;
          mode_d = int_clk_d;
        end

        if (complete) begin
          state_d = ST_IDLE;
          start_d = wr_sc ? wdata[7] : 1'b0;
          done_d  = 1'b1;
        end else if (wr_sc && !wdata[7]) begin
          state_d = ST_IDLE;
          sclk_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sb_q      <= 8'h00;
      start_q   <= 1'b0;
      int_clk_q <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= 3'd0;
      div_q     <= '0;
      sclk_q    <= 1'b1;
      sout_q    <= 1'b1;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      sync_q    <= 3'b111;
    end else begin
      state_q   <= state_d;
      sb_q      <= sb_d;
      start_q   <= start_d;
      int_clk_q <= int_clk_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
      irq_q     <= done_q;
      sync_q    <= {sync_q[1:0], sclk_in};
    end
  end

  assign sout             = sout_q;
  assign sclk_out         = sclk_q;
  assign serial_interrupt = irq_q;

endmodule
